// File: rtl/jk_counter_bank_if.sv
// Control, data and status signals between a jk_counter_bank and its user.
interface jk_counter_bank_if #(
  parameter int unsigned WIDTH = 8
);
  logic             pr;
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_bar;
  logic             tc;

  modport master (
    output pr, en, mode, j, k,
    input  q, q_bar, tc
  );

  modport slave (
    input  pr, en, mode, j, k,
    output q, q_bar, tc
  );
endinterface

// File: rtl/jk_counter_bank.sv
// Vector JK register / modulo up-down counter with preset and terminal-count pulse.
// Define JK_COUNTER_SAT_EN to make the count modes saturate instead of wrap.
module jk_counter_bank #(
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      MAX_COUNT  = 2**WIDTH - 1,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}},
  parameter int unsigned      RESET_VAL  = 0
) (
  input logic              clk,
  input logic              rst,
  jk_counter_bank_if.slave bus
);
  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_UP   = 2'b01;
  localparam logic [1:0] MODE_DOWN = 2'b10;

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE_Q   = WIDTH'(1);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] jk_next;
  logic             tc_reg;
  logic             tc_next;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_jk_bit
      always_comb begin
        jk_next[gi] = q_reg[gi];
        case ({bus.j[gi], bus.k[gi]})
          2'b01:   jk_next[gi] = 1'b0;
          2'b10:   jk_next[gi] = 1'b1;
          2'b11:   jk_next[gi] = ~q_reg[gi];
          default: jk_next[gi] = q_reg[gi];
        endcase
      end
    end
  endgenerate

  // Values above MAX_Q (reachable through JK mode or preset) are treated as
  // already at the limit when counting up; counting down from them is unclamped.
  always_comb begin
    q_next  = q_reg;
    tc_next = 1'b0;
    if (bus.pr) begin
      q_next = PRESET_VAL;
    end else if (bus.en) begin
      case (bus.mode)
        MODE_JK: q_next = jk_next;
        MODE_UP: begin
          if (q_reg >= MAX_Q) begin
`ifdef JK_COUNTER_SAT_EN
            q_next = MAX_Q;
`else
            q_next = '0;
`endif
            tc_next = 1'b1;
          end else begin
            q_next = q_reg + ONE_Q;
          end
        end
        MODE_DOWN: begin
          if (q_reg == '0) begin
`ifdef JK_COUNTER_SAT_EN
            q_next = '0;
`else
            q_next = MAX_Q;
`endif
            tc_next = 1'b1;
          end else begin
            q_next = q_reg - ONE_Q;
          end
        end
        default: q_next = q_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg  <= RESET_Q;
      tc_reg <= 1'b0;
    end else begin
      q_reg  <= q_next;
      tc_reg <= tc_next;
    end
  end

  assign bus.q     = q_reg;
  assign bus.q_bar = ~q_reg;
  assign bus.tc    = tc_reg;
endmodule

// File: tb/tb_jk_counter_bank.sv
// Directed self-checking bench for jk_counter_bank with WIDTH=8, MAX_COUNT=9.
module tb_jk_counter_bank;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  jk_counter_bank_if #(.WIDTH(8)) bus ();

  jk_counter_bank #(
    .WIDTH      (8),
    .MAX_COUNT  (9),
    .PRESET_VAL (8'hFF),
    .RESET_VAL  (0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] eq [3] = '{8'h00, 8'hFF, 8'h00};
    rst = 1'b1; bus.pr = 1'b0; bus.en = 1'b0; bus.mode = 2'b00;
    bus.j = 8'h00; bus.k = 8'h00;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin rst = 1'b0; bus.pr = 1'b1; end
      if (i == 2) begin rst = 1'b1; bus.pr = 1'b1; end
      tick();
      checks++;
      $display("reset step %0d: q=%h q_bar=%h tc=%b", i, bus.q, bus.q_bar, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], 1'b0}) begin
        errors++;
        $display("FAIL reset step %0d: got q=%h q_bar=%h tc=%b, expected q=%h q_bar=%h tc=0",
                 i, bus.q, bus.q_bar, bus.tc, eq[i], ~eq[i]);
      end
    end
    rst = 1'b0; bus.pr = 1'b0;
  endtask

  task automatic test_jk();
    logic [7:0] jv [4] = '{8'hF0, 8'hFF, 8'h00, 8'h00};
    logic [7:0] kv [4] = '{8'h00, 8'hFF, 8'h0C, 8'h00};
    logic [7:0] eq [4] = '{8'hF0, 8'h0F, 8'h03, 8'h03};
    bus.en = 1'b1; bus.mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      bus.j = jv[i]; bus.k = kv[i];
      tick();
      checks++;
      $display("jk step %0d: j=%h k=%h q=%h tc=%b", i, jv[i], kv[i], bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], 1'b0}) begin
        errors++;
        $display("FAIL jk step %0d: got q=%h q_bar=%h tc=%b, expected q=%h tc=0",
                 i, bus.q, bus.q_bar, bus.tc, eq[i]);
      end
    end
    bus.j = 8'h00; bus.k = 8'h00;
  endtask

  task automatic test_count_up();
    logic [7:0] eq [12] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0, 8'd1, 8'd2};
    logic       et [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    do_reset();
    bus.en = 1'b1; bus.mode = 2'b01;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      $display("up step %0d: q=%0d tc=%b", i, bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], et[i]}) begin
        errors++;
        $display("FAIL up step %0d: got q=%0d q_bar=%h tc=%b, expected q=%0d tc=%b",
                 i, bus.q, bus.q_bar, bus.tc, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_down_gating();
    logic [1:0] md [8] = '{2'b00, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    logic       ev [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    logic [7:0] eq [8] = '{8'd2, 8'd1, 8'd0, 8'd9, 8'd9, 8'd9, 8'd9, 8'd0};
    logic       et [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.mode = md[i]; bus.en = ev[i];
      bus.j = (i == 0) ? 8'h02 : 8'h00; bus.k = 8'h00;
      tick();
      checks++;
      $display("down step %0d: mode=%b en=%b q=%0d tc=%b", i, md[i], ev[i], bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], et[i]}) begin
        errors++;
        $display("FAIL down step %0d: got q=%0d q_bar=%h tc=%b, expected q=%0d tc=%b",
                 i, bus.q, bus.q_bar, bus.tc, eq[i], et[i]);
      end
    end
  endtask

  task automatic test_out_of_range();
    // JK-load 12, step down unclamped, wrap up, count to 5, reset, count to 9, reset on the wrap edge
    logic [1:0] md [19] = '{2'b00, 2'b10, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01,
                            2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    logic [7:0] eq [19] = '{8'd12, 8'd11, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0,
                            8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd0};
    logic       et [19] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 19; i++) begin
      bus.mode = md[i];
      bus.j = (i == 0) ? 8'h0C : 8'h00; bus.k = 8'h00;
      rst = (i == 8 || i == 18);
      tick();
      checks++;
      $display("range step %0d: mode=%b rst=%b q=%0d tc=%b", i, md[i], rst, bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], et[i]}) begin
        errors++;
        $display("FAIL range step %0d: got q=%0d q_bar=%h tc=%b, expected q=%0d tc=%b",
                 i, bus.q, bus.q_bar, bus.tc, eq[i], et[i]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hold();
    do_reset();
    bus.en = 1'b1; bus.mode = 2'b00; bus.j = 8'h5A; bus.k = 8'h00;
    tick();
    bus.mode = 2'b11; bus.j = 8'hFF; bus.k = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      $display("hold step %0d: q=%h tc=%b", i, bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {8'h5A, 8'hA5, 1'b0}) begin
        errors++;
        $display("FAIL hold step %0d: got q=%h q_bar=%h tc=%b, expected q=5a q_bar=a5 tc=0",
                 i, bus.q, bus.q_bar, bus.tc);
      end
    end
    bus.j = 8'h00; bus.k = 8'h00;
  endtask

  task automatic test_saturation();
    logic [1:0] md [7] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10};
    logic [7:0] jv [7] = '{8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] kv [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00};
    logic [7:0] eq [7] = '{8'd8, 8'd9, 8'd9, 8'd9, 8'd1, 8'd0, 8'd0};
    logic       et [7] = '{0, 0, 1, 1, 0, 0, 1};
    do_reset();
    bus.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.mode = md[i]; bus.j = jv[i]; bus.k = kv[i];
      tick();
      checks++;
      $display("sat step %0d: mode=%b q=%0d tc=%b", i, md[i], bus.q, bus.tc);
      if ({bus.q, bus.q_bar, bus.tc} !== {eq[i], ~eq[i], et[i]}) begin
        errors++;
        $display("FAIL sat step %0d: got q=%0d q_bar=%h tc=%b, expected q=%0d tc=%b",
                 i, bus.q, bus.q_bar, bus.tc, eq[i], et[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.pr = 1'b0; bus.en = 1'b0; bus.mode = 2'b00; bus.j = 8'h00; bus.k = 8'h00;
    test_reset();
    test_jk();
    test_hold();
`ifdef JK_COUNTER_SAT_EN
    test_saturation();
`else
    test_count_up();
    test_down_gating();
    test_out_of_range();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/jk_counter_bank.md
Name: jk_counter_bank

Overview:
- WIDTH-bit register bank that generalises the single JK flip-flop to a vector.
- Operating modes: per-bit JK register, modulo up-counter, modulo down-counter, hold.
- Synchronous preset, terminal-count flag and complementary outputs.
- Serves as the team's general clock-divider / event-counter primitive.

Parameters:
WIDTH, 8, bit width of q, j, k
MAX_COUNT, 2**WIDTH-1, modulo limit; count range 0..MAX_COUNT; must be <= 2**WIDTH-1
PRESET_VAL, {WIDTH{1'b1}}, value loaded by pr
RESET_VAL, 0, value loaded by rst

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous, active-high
pr  input  1  synchronous preset, active-high: q <= PRESET_VAL
en  input  1  clock enable for mode operations; pr and rst ignore en
mode  input  2  00 JK bank, 01 count up, 10 count down, 11 hold
j  input  WIDTH  per-bit J (JK mode only)
k  input  WIDTH  per-bit K (JK mode only)
q  output  WIDTH  registered state
q_bar  output  WIDTH  always ~q, combinational from q
tc  output  1  registered terminal-count pulse

Behaviour:
- Reset is synchronous and active-high. On a clk edge with rst=1: q <= RESET_VAL, tc <= 0.
- Edge priority: rst > pr > (en & mode). pr=1 loads q <= PRESET_VAL and tc <= 0.
- en=0 with no rst/pr: q holds, tc <= 0.
- JK mode (00), per bit i, on the edge:
  - j[i]k[i] = 00: hold.
  - 01: q[i] <= 0.
  - 10: q[i] <= 1.
  - 11: q[i] <= ~q[i].
  - tc <= 0.
- Count up (01):
  - q < MAX_COUNT: q <= q+1, tc <= 0.
  - q >= MAX_COUNT: q <= 0, tc <= 1. This covers out-of-range values loaded via JK mode or preset.
- Count down (10):
  - q == 0: q <= MAX_COUNT, tc <= 1.
  - otherwise: q <= q-1, tc <= 0. No clamp when q > MAX_COUNT.
- Hold (11): q holds, tc <= 0.
- tc timing: tc is high for exactly one cycle, the cycle in which q shows the post-wrap value. With en held high through consecutive wraps, tc fires once per wrap.
- Mode changes:
  - A new mode takes effect at the next edge and q carries over unchanged; there is no reload on mode switch.
  - An up/down reversal at a boundary uses the rules above with the current q.
- Arithmetic: WIDTH-bit unsigned. Internal compares use WIDTH bits; MAX_COUNT is truncated to WIDTH bits.
- Latency: one cycle from input sampling to q/tc. q_bar has zero latency relative to q.
- Reset mid-count: takes effect at the next edge regardless of mode/en/pr; any pending tc is cleared.

Optional Feature:
- Macro: JK_COUNTER_SAT_EN.
- Defined: count modes saturate instead of wrapping.
  - Up with q >= MAX_COUNT: q <= MAX_COUNT.
  - Down with q == 0: q stays 0.
  - tc <= 1 on every enabled edge where the step was blocked by saturation, so tc stays high while saturated and enabled.
  - JK mode is unaffected.
- Undefined: modulo wrap behaviour as specified above.

Test Plan:
- Reset/preset: WIDTH=8. rst=1 for one edge → q=0x00, q_bar=0xFF, tc=0. Then pr=1 → q=0xFF. pr and rst both 1 → q=0x00.
- JK mode: q=0x00; j=0xF0,k=0x00 → q=0xF0. Then j=0xFF,k=0xFF → q=0x0F. Then j=0x00,k=0x0C → q=0x03. Then j=k=0 → q holds 0x03. tc=0 throughout.
- Modulo up: MAX_COUNT=9, en=1, mode=01 from q=0 for 12 edges → q=1..9,0,1,2. tc=1 only in the cycle q=0 after 9.
- Down and gating: MAX_COUNT=9; from q=2, mode=10 → 1,0,9 with tc=1 at 9. Then en=0 for 3 edges → q holds 9, tc=0. Switching to mode=01 at q=9 → next q=0, tc=1.
- Out-of-range and mid-op reset: MAX_COUNT=9; JK-set q=12, mode=01 → q=0, tc=1. Assert rst while counting at q=5 → next q=0, tc=0.
- Saturation (JK_COUNTER_SAT_EN defined): MAX_COUNT=9; count up from 8 → 9, then 9,9 with tc=1,1. Count down from 1 → 0, then 0 with tc=1.
